// File: rtl/eb_assist_pkg.sv
// rtl/eb_assist_pkg.sv - shared types and constants for the assist-level controller
package eb_assist_pkg;

  typedef enum logic [1:0] {ACTIVE, OFF, LOWBATT} assist_state_t;
  typedef logic [1:0] setting_t;

  localparam setting_t SETTING_RST = 2'b10;
  localparam logic [7:0] GAIN_TBL [4] = '{8'd64, 8'd128, 8'd192, 8'd255};

  // Low-battery operation never runs above level 1.
  function automatic setting_t lowbatt_cap(input setting_t s);
    return (s > 2'd1) ? 2'd1 : s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer and debounce with rise/fall pulses
module btn_debounce #(
  parameter int DB_CNT = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(DB_CNT + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      // Any sample agreeing with the accepted level restarts the stability count.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CNT - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
        r_fall  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/assist_mode_ctrl.sv
// rtl/assist_mode_ctrl.sv - assist-level FSM, press classification and torque gain ramp
module assist_mode_ctrl
  import eb_assist_pkg::*;
#(
  parameter int DB_CNT    = 50_000,
  parameter int LONG_CNT  = 50_000_000,
  parameter int RAMP_DIV  = 10_000,
  parameter int RAMP_STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tgglMd,
  input  logic       batt_low,
  output logic [1:0] setting,
  output logic       assist_en,
  output logic [7:0] gain,
  output logic       ramp_busy
);

  localparam int TW = $clog2(LONG_CNT + 1);
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [7:0] STEP8 = 8'(RAMP_STEP);

  logic          w_level;
  logic          w_rise;
  logic          w_fall;
  logic          w_short;
  logic          w_long;
  logic [TW-1:0] r_timer;

  assist_state_t r_state;
  assist_state_t w_ent;
  assist_state_t w_nxt_state;
  setting_t      r_set;
  setting_t      w_nxt_set;
  setting_t      w_nxt_eff;

  logic [PW-1:0] r_pre;
  logic          w_step;
  logic [7:0]    w_target;
  logic [7:0]    w_gain_nxt;

  btn_debounce #(.DB_CNT(DB_CNT)) u_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (tgglMd),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Timer holds its count through the fall cycle so the release can be classified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (!w_level) begin
      r_timer <= '0;
    end else if (w_rise) begin
      r_timer <= TW'(1);
    end else if (r_timer != TW'(LONG_CNT)) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_long  = w_level && (r_timer == TW'(LONG_CNT - 1));
  assign w_short = w_fall && (r_timer < TW'(LONG_CNT));

  // A battery-low entry in the same cycle as a press makes the press obey LOWBATT rules.
  always_comb begin
    w_ent       = (r_state == ACTIVE && batt_low) ? LOWBATT : r_state;
    w_nxt_state = w_ent;
    w_nxt_set   = r_set;
    case (w_ent)
      ACTIVE: begin
        if (w_long)       w_nxt_state = OFF;
        else if (w_short) w_nxt_set   = r_set + 2'd1;
      end
      OFF: begin
        if (w_long) w_nxt_state = batt_low ? LOWBATT : ACTIVE;
      end
      LOWBATT: begin
        if (w_long)         w_nxt_state = OFF;
        else if (!batt_low) w_nxt_state = ACTIVE;
        if (w_short && !w_long)
          w_nxt_set = (lowbatt_cap(r_set) == 2'd0) ? 2'd1 : 2'd0;
      end
      default: w_nxt_state = ACTIVE;
    endcase
    w_nxt_eff = (w_nxt_state == LOWBATT) ? lowbatt_cap(w_nxt_set) : w_nxt_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ACTIVE;
      r_set     <= SETTING_RST;
      setting   <= SETTING_RST;
      assist_en <= 1'b1;
    end else begin
      r_state   <= w_nxt_state;
      r_set     <= w_nxt_set;
      setting   <= w_nxt_eff;
      assist_en <= (w_nxt_state != OFF);
    end
  end

  assign w_target = assist_en ? GAIN_TBL[setting] : 8'd0;
  assign w_step   = (r_pre == PW'(RAMP_DIV - 1));

  // Clamp to the target on the final step so the gain never overshoots or wraps.
  always_comb begin
    w_gain_nxt = gain;
    if (w_step) begin
      if (gain < w_target)
        w_gain_nxt = ((w_target - gain) <= STEP8) ? w_target : gain + STEP8;
      else if (gain > w_target)
        w_gain_nxt = ((gain - w_target) <= STEP8) ? w_target : gain - STEP8;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre     <= '0;
      gain      <= 8'd0;
      ramp_busy <= 1'b1;
    end else begin
      r_pre     <= w_step ? '0 : r_pre + 1'b1;
      gain      <= w_gain_nxt;
      ramp_busy <= (w_gain_nxt != w_target);
    end
  end

endmodule

// File: tb/tb_assist_mode_ctrl.sv
// tb/tb_assist_mode_ctrl.sv - self-checking bench for assist_mode_ctrl
module tb_assist_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tgglMd;
  logic       batt_low;
  logic [1:0] setting;
  logic       assist_en;
  logic [7:0] gain;
  logic       ramp_busy;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = active, 1 = off, 2 = low battery
  int m_state;
  int m_set;
  bit m_batt;
  int tbl [4] = '{64, 128, 192, 255};

  always #5 clk = ~clk;

  assist_mode_ctrl #(
    .DB_CNT(4), .LONG_CNT(40), .RAMP_DIV(2), .RAMP_STEP(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tgglMd    (tgglMd),
    .batt_low  (batt_low),
    .setting   (setting),
    .assist_en (assist_en),
    .gain      (gain),
    .ramp_busy (ramp_busy)
  );

  function automatic int m_eff();
    if (m_state == 2) return (m_set > 1) ? 1 : m_set;
    return m_set;
  endfunction

  function automatic int m_target();
    if (m_state == 1) return 0;
    return tbl[m_eff()];
  endfunction

  function automatic bit m_en();
    return m_state != 1;
  endfunction

  task automatic model_short();
    if (m_state == 0) m_set = (m_set + 1) % 4;
    else if (m_state == 2) m_set = (m_eff() == 0) ? 1 : 0;
  endtask

  task automatic model_long();
    if (m_state == 1) m_state = m_batt ? 2 : 0;
    else m_state = 1;
  endtask

  task automatic model_batt();
    if (m_batt && m_state == 0) m_state = 2;
    else if (!m_batt && m_state == 2) m_state = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    tgglMd = 1'b1;
    tick(n);
    tgglMd = 1'b0;
    tick(14);
  endtask

  task automatic wait_ramp(output bit ok);
    ok = 1'b0;
    tick(3);
    for (int i = 0; i < 400; i++) begin
      if (!ramp_busy) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tgglMd = 1'b0; batt_low = 1'b0;
    m_state = 0; m_set = 2; m_batt = 1'b0;
    tick(3);
    checks++; if (setting !== 2'd2) begin errors++; $display("FAIL reset_setting got %0d want 2", setting); end
    checks++; if (assist_en !== 1'b1) begin errors++; $display("FAIL reset_assist_en got %0b want 1", assist_en); end
    checks++; if (gain !== 8'd0) begin errors++; $display("FAIL reset_gain got %0d want 0", gain); end
    checks++; if (ramp_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b want 1", ramp_busy); end
    rst_n = 1'b1;
    tick(95);
    checks++; if (gain !== 8'd188 || ramp_busy !== 1'b1) begin errors++; $display("FAIL ramp_47_steps got gain=%0d busy=%0b want 188/1", gain, ramp_busy); end
    tick(1);
    checks++; if (gain !== 8'd192 || ramp_busy !== 1'b0) begin errors++; $display("FAIL ramp_48_steps got gain=%0d busy=%0b want 192/0", gain, ramp_busy); end
  endtask

  task automatic test_short_press();
    bit ok;
    for (int k = 0; k < 2; k++) begin
      press(10);
      model_short();
      checks++; if (setting !== 2'(m_eff())) begin errors++; $display("FAIL short_setting_%0d got %0d want %0d", k, setting, m_eff()); end
      wait_ramp(ok);
      checks++; if (!ok || gain !== 8'(m_target())) begin errors++; $display("FAIL short_gain_%0d got %0d settled=%0b want %0d", k, gain, ok, m_target()); end
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 3; k++) begin
      tgglMd = 1'b1; tick(1);
      tgglMd = 1'b0; tick(6);
    end
    tgglMd = 1'b1; tick(3);
    tgglMd = 1'b0; tick(20);
    checks++; if (setting !== 2'(m_eff())) begin errors++; $display("FAIL glitch_setting got %0d want %0d", setting, m_eff()); end
    checks++; if (gain !== 8'(m_target()) || ramp_busy !== 1'b0) begin errors++; $display("FAIL glitch_gain got %0d busy=%0b want %0d/0", gain, ramp_busy, m_target()); end
  endtask

  task automatic test_long_press();
    bit ok;
    tgglMd = 1'b1;
    tick(50);
    model_long();
    checks++; if (assist_en !== 1'b0) begin errors++; $display("FAIL long_off_en got %0b want 0", assist_en); end
    tgglMd = 1'b0;
    tick(14);
    checks++; if (assist_en !== 1'b0 || setting !== 2'(m_eff())) begin errors++; $display("FAIL long_release got en=%0b set=%0d want 0/%0d", assist_en, setting, m_eff()); end
    wait_ramp(ok);
    checks++; if (!ok || gain !== 8'd0) begin errors++; $display("FAIL long_gain_zero got %0d settled=%0b want 0", gain, ok); end
    press(50);
    model_long();
    checks++; if (assist_en !== 1'b1) begin errors++; $display("FAIL long_on_en got %0b want 1", assist_en); end
    wait_ramp(ok);
    checks++; if (!ok || gain !== 8'(m_target())) begin errors++; $display("FAIL long_on_gain got %0d want %0d", gain, m_target()); end
  endtask

  task automatic test_batt_low();
    bit ok;
    while (m_set != 3) begin
      press(10);
      model_short();
    end
    checks++; if (setting !== 2'd3) begin errors++; $display("FAIL batt_pre_setting got %0d want 3", setting); end
    batt_low = 1'b1; m_batt = 1'b1; model_batt();
    tick(2);
    checks++; if (setting !== 2'(m_eff())) begin errors++; $display("FAIL batt_cap_setting got %0d want %0d", setting, m_eff()); end
    wait_ramp(ok);
    checks++; if (!ok || gain !== 8'(m_target())) begin errors++; $display("FAIL batt_gain got %0d want %0d", gain, m_target()); end
    batt_low = 1'b0; m_batt = 1'b0; model_batt();
    tick(2);
    checks++; if (setting !== 2'(m_eff())) begin errors++; $display("FAIL batt_restore got %0d want %0d", setting, m_eff()); end
    wait_ramp(ok);
    checks++; if (!ok || gain !== 8'(m_target())) begin errors++; $display("FAIL batt_restore_gain got %0d want %0d", gain, m_target()); end
  endtask

  task automatic test_random();
    bit ok;
    int op;
    for (int it = 0; it < 16; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        press($urandom_range(8, 30));
        model_short();
      end else if (op == 1) begin
        press($urandom_range(50, 60));
        model_long();
      end else begin
        m_batt = ~m_batt;
        batt_low = m_batt;
        model_batt();
        tick(3);
      end
      checks++; if (setting !== 2'(m_eff()) || assist_en !== m_en()) begin errors++; $display("FAIL rand_%0d_mode op=%0d got set=%0d en=%0b want %0d/%0b", it, op, setting, assist_en, m_eff(), m_en()); end
      wait_ramp(ok);
      checks++; if (!ok || gain !== 8'(m_target())) begin errors++; $display("FAIL rand_%0d_gain got %0d settled=%0b want %0d", it, gain, ok, m_target()); end
    end
  endtask

  task automatic test_reset_mid();
    tgglMd = 1'b1;
    tick(20);
    rst_n = 1'b0;
    #1;
    checks++; if (setting !== 2'd2 || gain !== 8'd0 || assist_en !== 1'b1) begin errors++; $display("FAIL async_reset got set=%0d gain=%0d en=%0b want 2/0/1", setting, gain, assist_en); end
    tgglMd = 1'b0; batt_low = 1'b0;
    m_state = 0; m_set = 2; m_batt = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(30);
    checks++; if (setting !== 2'd2 || assist_en !== 1'b1) begin errors++; $display("FAIL post_reset_press got set=%0d en=%0b want 2/1", setting, assist_en); end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_glitch();
    test_long_press();
    test_batt_low();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
